// File: rtl/tdc_pkg.sv
// Shared definitions for the multi-channel TDC capture block.
//   tdc_state_t : measurement sequencer states
//   ch_width    : channel-index width (at least 1 bit, even for a single channel)
//   rec_width   : packed result record width {channel, coarse, fine, timeout}
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_MEASURING = 2'd2,
    ST_FLUSH     = 2'd3
  } tdc_state_t;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned rec_width(input int unsigned num_ch,
                                            input int unsigned coarse_w,
                                            input int unsigned fine_w);
    return ch_width(num_ch) + coarse_w + fine_w + 1;
  endfunction

endpackage

// File: rtl/tdc_result_fifo.sv
// Synchronous first-word-fall-through FIFO for TDC result records.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : push request and record
//   rd_en             : pop the head record (ignored when empty)
//   rd_data           : head record, forced to zero while empty
//   full, empty       : occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tdc_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tdc_multi_channel_capture.sv
// Multi-channel time-to-digital converter capture and result streaming.
//   clk, rst            : clock, synchronous active-high reset
//   tdc_enable          : level enable; low returns to IDLE and drops pending records
//   tdc_arm             : pulse; arms a measurement from IDLE
//   continuous_mode     : re-arm automatically after each measurement
//   tdc_start           : shared start (rising edge begins measuring)
//   tdc_stop            : per-channel stop (rising edge captures the channel)
//   fine_code           : per-channel delay-line tap codes, valid with the stop edge
//   out_valid/out_ready : result stream handshake
//   out_channel, out_coarse, out_fine, out_timeout : result record
//   tdc_busy            : measurement in progress (ARMED, MEASURING, FLUSH)
//   overflow_error      : sticky, a record was dropped on a full FIFO
//   measurement_count   : completed measurements
module tdc_multi_channel_capture
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned COARSE_W       = 16,
  parameter int unsigned FINE_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tdc_enable,
  input  logic                         tdc_arm,
  input  logic                         continuous_mode,
  input  logic                         tdc_start,
  input  logic [NUM_CH-1:0]            tdc_stop,
  input  logic [NUM_CH*FINE_W-1:0]     fine_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ch_width(NUM_CH)-1:0]  out_channel,
  output logic [COARSE_W-1:0]          out_coarse,
  output logic [FINE_W-1:0]            out_fine,
  output logic                         out_timeout,
  output logic                         tdc_busy,
  output logic                         overflow_error,
  output logic [31:0]                  measurement_count
);

  localparam int unsigned         CH_W        = ch_width(NUM_CH);
  localparam int unsigned         REC_W       = rec_width(NUM_CH, COARSE_W, FINE_W);
  localparam logic [COARSE_W-1:0] TIMEOUT_VAL = COARSE_W'(TIMEOUT_CYCLES);

  tdc_state_t state;
  tdc_state_t state_next;

  logic                start_q;
  logic [NUM_CH-1:0]   stop_q;
  logic                start_rise;
  logic [NUM_CH-1:0]   stop_rise;

  logic [COARSE_W-1:0] coarse_cnt;
  logic                timeout_hit;
  logic                flush_done;

  logic [NUM_CH-1:0]   done;
  logic [NUM_CH-1:0]   pend_vld;
  logic [COARSE_W-1:0] pend_coarse [NUM_CH];
  logic [FINE_W-1:0]   pend_fine   [NUM_CH];
  logic [NUM_CH-1:0]   pend_to;
  logic [NUM_CH-1:0]   stop_cap;
  logic [NUM_CH-1:0]   to_cap;

  logic                arb_en;
  logic                grant_vld;
  logic [CH_W-1:0]     grant_idx;
  logic [NUM_CH-1:0]   grant_oh;
  logic [CH_W-1:0]     last_grant;
  logic                hi_hit;
  logic                lo_hit;
  logic [CH_W-1:0]     hi_idx;
  logic [CH_W-1:0]     lo_idx;

  logic [REC_W-1:0]    wr_data;
  logic [REC_W-1:0]    fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;

  assign start_rise = tdc_start & ~start_q;
  assign stop_rise  = tdc_stop & ~stop_q;

  assign timeout_hit = (state == ST_MEASURING) && (coarse_cnt == TIMEOUT_VAL);
  // A stop edge landing on the timeout count keeps its real measurement.
  assign stop_cap    = (state == ST_MEASURING) ? (stop_rise & ~done) : '0;
  assign to_cap      = timeout_hit ? ~(done | stop_cap) : '0;

  assign arb_en = tdc_enable && ((state == ST_MEASURING) || (state == ST_FLUSH));

  always_comb begin
    state_next = state;
    flush_done = 1'b0;
    case (state)
      ST_IDLE:      if (tdc_arm) state_next = ST_ARMED;
      ST_ARMED:     if (start_rise) state_next = ST_MEASURING;
      ST_MEASURING: if (timeout_hit || (&(done | stop_cap))) state_next = ST_FLUSH;
      ST_FLUSH: begin
        if (pend_vld == '0) begin
          flush_done = 1'b1;
          state_next = continuous_mode ? ST_ARMED : ST_IDLE;
        end
      end
      default:      state_next = ST_IDLE;
    endcase
    if (!tdc_enable) begin
      state_next = ST_IDLE;
      flush_done = 1'b0;
    end
  end

  // Round-robin: lowest pending channel above the last grant wins,
  // otherwise wrap to the lowest pending channel at or below it.
  always_comb begin
    hi_hit   = 1'b0;
    lo_hit   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    grant_oh = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (arb_en && pend_vld[c]) begin
        if (c > 32'(last_grant)) begin
          if (!hi_hit) begin
            hi_hit = 1'b1;
            hi_idx = CH_W'(c);
          end
        end else if (!lo_hit) begin
          lo_hit = 1'b1;
          lo_idx = CH_W'(c);
        end
      end
    end
    grant_vld = hi_hit | lo_hit;
    grant_idx = hi_hit ? hi_idx : lo_idx;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      grant_oh[c] = grant_vld && (32'(grant_idx) == c);
    end
  end

  always_comb begin
    wr_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_oh[c]) wr_data = {CH_W'(c), pend_coarse[c], pend_fine[c], pend_to[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      start_q           <= 1'b0;
      stop_q            <= '0;
      coarse_cnt        <= '0;
      last_grant        <= CH_W'(NUM_CH - 1);
      overflow_error    <= 1'b0;
      measurement_count <= '0;
    end else begin
      state   <= state_next;
      start_q <= tdc_start;
      stop_q  <= tdc_stop;
      if (!tdc_enable) begin
        coarse_cnt <= '0;
      end else begin
        case (state)
          ST_ARMED:     coarse_cnt <= start_rise ? COARSE_W'(1) : '0;
          ST_MEASURING: if (!timeout_hit) coarse_cnt <= coarse_cnt + 1'b1;
          ST_FLUSH:     coarse_cnt <= coarse_cnt;
          default:      coarse_cnt <= '0;
        endcase
      end
      if (grant_vld) last_grant <= grant_idx;
      if (grant_vld && fifo_full && !out_ready) overflow_error <= 1'b1;
      if (flush_done) measurement_count <= measurement_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= '0;
      pend_vld <= '0;
      pend_to  <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        pend_coarse[c] <= '0;
        pend_fine[c]   <= '0;
      end
    end else if (!tdc_enable || (state == ST_IDLE) || (state == ST_ARMED)) begin
      done     <= '0;
      pend_vld <= '0;
    end else begin
      done     <= done | stop_cap | to_cap;
      // Granted records leave pending whether the FIFO took them or not.
      pend_vld <= (pend_vld & ~grant_oh) | stop_cap | to_cap;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (stop_cap[c]) begin
          pend_coarse[c] <= coarse_cnt;
          pend_fine[c]   <= fine_code[c*FINE_W +: FINE_W];
          pend_to[c]     <= 1'b0;
        end else if (to_cap[c]) begin
          pend_coarse[c] <= TIMEOUT_VAL;
          pend_fine[c]   <= '0;
          pend_to[c]     <= 1'b1;
        end
      end
    end
  end

  tdc_result_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (grant_vld),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {out_channel, out_coarse, out_fine, out_timeout} = fifo_rd_data;
  assign out_valid = !fifo_empty;
  assign tdc_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_tdc_multi_channel_capture.sv
// Directed and randomized bench for tdc_multi_channel_capture.
// Expected records come from each channel's stop offset relative to the
// start edge: offset <= TMO gives {offset, fine, 0}, otherwise {TMO, 0, 1}.
module tb_tdc_multi_channel_capture;

  localparam int NCH = 4;
  localparam int TMO = 100;

  logic                clk = 1'b0;
  logic                rst;
  logic                tdc_enable;
  logic                tdc_arm;
  logic                continuous_mode;
  logic                tdc_start;
  logic [NCH-1:0]      tdc_stop;
  logic [NCH*8-1:0]    fine_code;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_channel;
  logic [15:0]         out_coarse;
  logic [7:0]          out_fine;
  logic                out_timeout;
  logic                tdc_busy;
  logic                overflow_error;
  logic [31:0]         measurement_count;

  tdc_multi_channel_capture #(
    .NUM_CH         (NCH),
    .COARSE_W       (16),
    .FINE_W         (8),
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .tdc_enable        (tdc_enable),
    .tdc_arm           (tdc_arm),
    .continuous_mode   (continuous_mode),
    .tdc_start         (tdc_start),
    .tdc_stop          (tdc_stop),
    .fine_code         (fine_code),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_channel       (out_channel),
    .out_coarse        (out_coarse),
    .out_fine          (out_fine),
    .out_timeout       (out_timeout),
    .tdc_busy          (tdc_busy),
    .overflow_error    (overflow_error),
    .measurement_count (measurement_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int coarse;
    int fine;
    int to;
  } rec_t;

  rec_t       got_q[$];
  int         ord_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_mcount = 0;

  int         stop_off [NCH];
  logic [7:0] fine_v   [NCH];
  int         dup_off;
  int         restart_off;
  int         ready_on_off;
  int         rst_off;
  bit         pre_stop;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back('{int'(out_channel), int'(out_coarse), int'(out_fine), int'(out_timeout)});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_opts();
    dup_off      = -1;
    restart_off  = -1;
    ready_on_off = -1;
    rst_off      = -10;
    pre_stop     = 1'b0;
  endtask

  task automatic random_offsets();
    for (int c = 0; c < NCH; c++) begin
      stop_off[c] = $urandom_range(1, 120);
      fine_v[c]   = 8'($urandom());
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic drive_burst(input bit do_arm);
    if (do_arm) begin
      tdc_arm = 1'b1;
      tick(1);
      tdc_arm = 1'b0;
    end
    if (pre_stop) begin
      tdc_stop = 4'b0001;
      tick(1);
      tdc_stop = '0;
    end
    tdc_start = 1'b1;
    for (int cyc = 1; cyc <= 115; cyc++) begin
      tick(1);
      tdc_start = (cyc == restart_off);
      tdc_stop  = '0;
      fine_code = $urandom();
      for (int c = 0; c < NCH; c++) begin
        if (stop_off[c] == cyc) begin
          tdc_stop[c] = 1'b1;
          fine_code[c*8 +: 8] = fine_v[c];
        end
      end
      if (cyc == dup_off) begin
        tdc_stop[0] = 1'b1;
        fine_code[7:0] = ~fine_v[0];
      end
      if (cyc == ready_on_off) out_ready = 1'b1;
      rst = (cyc == rst_off);
      if (cyc == rst_off + 1) begin
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(tdc_busy), 64'(0));
      end
    end
    tdc_stop = '0;
    rst      = 1'b0;
  endtask

  task automatic verify(input string tag, input int exp_n);
    bit   seen [NCH];
    rec_t r;
    int   ec, ef, et;
    for (int c = 0; c < NCH; c++) seen[c] = 1'b0;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_n));
    for (int i = 0; i < got_q.size(); i++) begin
      r = got_q[i];
      if (stop_off[r.ch] <= TMO) begin
        ec = stop_off[r.ch];
        ef = int'(fine_v[r.ch]);
        et = 0;
      end else begin
        ec = TMO;
        ef = 0;
        et = 1;
      end
      check({tag, "_dup_channel"}, 64'(seen[r.ch]), 64'(0));
      seen[r.ch] = 1'b1;
      check({tag, "_coarse"},  64'(r.coarse), 64'(ec));
      check({tag, "_fine"},    64'(r.fine),   64'(ef));
      check({tag, "_timeout"}, 64'(r.to),     64'(et));
      if (i < ord_q.size()) check({tag, "_order"}, 64'(r.ch), 64'(ord_q[i]));
    end
    got_q.delete();
    ord_q.delete();
  endtask

  initial begin
    rst             = 1'b1;
    tdc_enable      = 1'b1;
    tdc_arm         = 1'b0;
    continuous_mode = 1'b0;
    tdc_start       = 1'b0;
    tdc_stop        = '0;
    fine_code       = '0;
    out_ready       = 1'b1;
    clear_opts();
    tick(3);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(tdc_busy), 64'(0));
    check("reset_overflow", 64'(overflow_error), 64'(0));
    check("reset_mcount", 64'(measurement_count), 64'(0));
    check("reset_out_rec", 64'({out_channel, out_coarse, out_fine, out_timeout}), 64'(0));
    rst = 1'b0;
    tick(2);

    // Basic four-channel measurement, ch1/ch2 simultaneous.
    stop_off = '{5, 9, 9, 20};
    fine_v   = '{8'h11, 8'h22, 8'h33, 8'h44};
    ord_q    = '{0, 1, 2, 3};
    drive_burst(1'b1);
    tick(5);
    verify("basic", 4);
    exp_mcount++;
    check("basic_mcount", 64'(measurement_count), 64'(exp_mcount));
    check("basic_idle", 64'(tdc_busy), 64'(0));

    // Only ch2 stops; the rest time out.
    stop_off = '{999, 999, 40, 999};
    fine_v   = '{8'h5a, 8'h6b, 8'h7c, 8'h8d};
    ord_q    = '{2, 3, 0, 1};
    drive_burst(1'b1);
    tick(5);
    verify("timeout", 4);
    exp_mcount++;
    check("timeout_mcount", 64'(measurement_count), 64'(exp_mcount));

    // Stops around the timeout boundary.
    stop_off = '{100, 101, 99, 50};
    fine_v   = '{8'hc1, 8'hc2, 8'hc3, 8'hc4};
    drive_burst(1'b1);
    tick(5);
    verify("boundary", 4);
    exp_mcount++;

    // Overflow with a two-entry FIFO and no reader.
    out_ready = 1'b0;
    stop_off  = '{3, 4, 5, 6};
    fine_v    = '{8'ha1, 8'ha2, 8'ha3, 8'ha4};
    drive_burst(1'b1);
    exp_mcount++;
    check("ovf_flag", 64'(overflow_error), 64'(1));
    for (int i = 0; i < 3; i++) begin
      check("ovf_hold_valid", 64'(out_valid), 64'(1));
      check("ovf_hold_rec", 64'({out_channel, out_coarse, out_fine, out_timeout}),
            64'({2'd0, 16'd3, 8'ha1, 1'b0}));
      tick(1);
    end
    out_ready = 1'b1;
    ord_q     = '{0, 1};
    tick(6);
    verify("overflow", 2);
    check("ovf_mcount", 64'(measurement_count), 64'(exp_mcount));

    // Reset in the middle of a measurement after two stops.
    out_ready = 1'b0;
    stop_off  = '{3, 5, 999, 999};
    rst_off   = 7;
    drive_burst(1'b1);
    clear_opts();
    exp_mcount = 0;
    out_ready  = 1'b1;
    tick(4);
    verify("reset_mid", 0);
    check("rstmid_overflow", 64'(overflow_error), 64'(0));
    check("rstmid_mcount", 64'(measurement_count), 64'(exp_mcount));
    // Without a fresh arm, start and stops do nothing.
    stop_off = '{2, 3, 4, 5};
    drive_burst(1'b0);
    tick(4);
    verify("no_arm", 0);
    check("no_arm_busy", 64'(tdc_busy), 64'(0));

    // FIFO full with a simultaneous pop must still accept the push.
    out_ready    = 1'b0;
    stop_off     = '{3, 3, 3, 3};
    fine_v       = '{8'h01, 8'h02, 8'h03, 8'h04};
    ready_on_off = 6;
    drive_burst(1'b1);
    clear_opts();
    tick(5);
    verify("full_rw", 4);
    exp_mcount++;
    check("full_rw_overflow", 64'(overflow_error), 64'(0));

    // Stop before start, duplicate stop, restart while measuring.
    pre_stop    = 1'b1;
    dup_off     = 8;
    restart_off = 6;
    stop_off    = '{4, 10, 12, 15};
    fine_v      = '{8'hd0, 8'hd1, 8'hd2, 8'hd3};
    drive_burst(1'b1);
    clear_opts();
    tick(5);
    verify("ignored_edges", 4);
    exp_mcount++;
    check("ignored_mcount", 64'(measurement_count), 64'(exp_mcount));

    // Randomized single measurements.
    for (int k = 0; k < 4; k++) begin
      random_offsets();
      drive_burst(1'b1);
      tick(5);
      verify("random", 4);
      exp_mcount++;
      check("random_mcount", 64'(measurement_count), 64'(exp_mcount));
    end

    // Continuous mode: one arm, three bursts.
    continuous_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      random_offsets();
      drive_burst(k == 0);
      verify("continuous", 4);
      exp_mcount++;
      check("continuous_mcount", 64'(measurement_count), 64'(exp_mcount));
    end
    check("continuous_rearmed", 64'(tdc_busy), 64'(1));
    continuous_mode = 1'b0;
    tdc_enable      = 1'b0;
    tick(1);
    check("enable_low_idle", 64'(tdc_busy), 64'(0));
    tdc_enable = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_multi_channel_capture.md
TDC_MULTI_CHANNEL_CAPTURE -- requirements
Module: tdc_multi_channel_capture

Interface
REQ-001 Parameter NUM_CH, default 4: number of stop channels (1..16).
REQ-002 Parameter COARSE_W, default 16: coarse counter width.
REQ-003 Parameter FINE_W, default 8: delay-line tap code width per channel.
REQ-004 Parameter FIFO_DEPTH, default 16: result FIFO entries (power of two, >=2).
REQ-005 Parameter TIMEOUT_CYCLES, default 65535: coarse count that ends a measurement (<= 2**COARSE_W-1).
REQ-006 Port clk  in  1  single clock; all logic on its rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port tdc_enable  in  1  level; low forces IDLE.
REQ-009 Port tdc_arm  in  1  one-cycle pulse; arms a measurement.
REQ-010 Port continuous_mode  in  1  auto re-arm after each measurement.
REQ-011 Port tdc_start  in  1  shared start, clk-synchronous.
REQ-012 Port tdc_stop  in  NUM_CH  per-channel stop, clk-synchronous.
REQ-013 Port fine_code  in  NUM_CH*FINE_W  per-channel tap code, valid in the stop-edge cycle.
REQ-014 Port out_valid / out_ready  out / in  1 / 1  result stream handshake.
REQ-015 Port out_channel / out_coarse / out_fine / out_timeout  out  clog2(NUM_CH) / COARSE_W / FINE_W / 1  result record.
REQ-016 Port tdc_busy  out  1  high in ARMED, MEASURING, FLUSH.
REQ-017 Port overflow_error  out  1  sticky FIFO-full drop flag.
REQ-018 Port measurement_count  out  32  completed measurements.

Function
REQ-019 States: IDLE, ARMED, MEASURING, FLUSH.
REQ-020 IDLE->ARMED on tdc_arm && tdc_enable.
REQ-021 Rising edge = input high this cycle, low previous cycle (per-input registered copy).
REQ-022 ARMED->MEASURING on tdc_start rising edge; coarse counter = 0 that cycle, +1 each following cycle.
REQ-023 Per-channel stop rising edge in MEASURING captures {channel, coarse, fine_code slice, timeout=0} into that channel's pending register once; later stop edges on a done channel are ignored.
REQ-024 Stop edges in IDLE/ARMED and start edges in MEASURING are ignored.
REQ-025 Coarse counter reaching TIMEOUT_CYCLES: every not-done channel gets record {coarse=TIMEOUT_CYCLES, fine=0, timeout=1}; -> FLUSH.
REQ-026 All channels done -> FLUSH next cycle; stop edge simultaneous with timeout count takes the normal (timeout=0) record.
REQ-027 FLUSH: round-robin arbiter writes one pending record per cycle to FIFO, starting after last granted channel; records pending simultaneously leave in round-robin order.
REQ-028 FLUSH exit when no pending: measurement_count +1; -> ARMED if continuous_mode && tdc_enable, else IDLE.
REQ-029 Arbiter also drains pending records during MEASURING (early channels not delayed to FLUSH).
REQ-030 Latency: stop edge in cycle k -> pending end of k -> FIFO write end of k+1 (if granted, FIFO empty) -> out_valid high cycle k+2.
REQ-031 FIFO full at write: record dropped, pending cleared, overflow_error set until rst.
REQ-032 FIFO write and read same cycle when full: read frees slot, write accepted.
REQ-033 out_* stable while out_valid && !out_ready; record pops on out_valid && out_ready.
REQ-034 tdc_enable low: next cycle IDLE, pending records discarded, FIFO contents retained and readable.
REQ-035 tdc_arm outside IDLE ignored.

Reset
REQ-036 rst: state IDLE, counters 0, pending cleared, FIFO empty, out_valid 0, out_* 0, tdc_busy 0, overflow_error 0, measurement_count 0; applies mid-measurement with no record emitted.

Structure
REQ-037 Package tdc_pkg holds state enum and record type/width function (clog2(NUM_CH)+COARSE_W+FINE_W+1).
REQ-038 One sub-module tdc_result_fifo: synchronous first-word-fall-through FIFO, parametrised width/depth, full/empty outputs.

Verification
REQ-039 arm, start, stops ch0..3 at coarse 5,9,9,20 with fine 0x11..0x44 -> four records in order ch0,ch1,ch2,ch3 with coarse 5,9,9,20, timeout 0; measurement_count=1.
REQ-040 TIMEOUT_CYCLES=100, only ch2 stops at 40 -> ch2 coarse 40; ch0,ch1,ch3 coarse 100, fine 0, timeout 1.
REQ-041 FIFO_DEPTH=2, out_ready=0, four stops -> two records held, overflow_error=1, out_* stable; then ready=1 -> exactly two records.
REQ-042 continuous_mode=1, three start/stop bursts without re-arm -> measurement_count=3, 3*NUM_CH records.
REQ-043 rst asserted mid-MEASURING after two stops -> out_valid 0 next cycle, FIFO empty, state IDLE, subsequent stops ignored until arm.
REQ-044 Stop before start, duplicate stop, start during MEASURING -> none produce extra records.
